// File: rtl/uc_fsm.sv
// Control unit for the 8-bit microcontroller: opcode decode, boot/flush bubbles, HALT.
// Optional illegal-opcode trap enabled by defining UC_ILLEGAL_TRAP_EN.
module uc_fsm #(
    parameter int unsigned RET_W       = 16,
    parameter int unsigned BOOT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Opcode,
    input  logic             zero,
    output logic             s_inc,
    output logic             s_inm,
    output logic             we,
    output logic             wez,
    output logic [2:0]       ALUOp,
    output logic             pc_en,
    output logic             halted,
    output logic             illegal,
    output logic [RET_W-1:0] retired
);

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    localparam int unsigned         BOOT_W    = 4;
    localparam logic [BOOT_W-1:0]   BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);
    localparam logic [RET_W-1:0]    RET_MAX   = '1;

    localparam logic [1:0] CL_ALU_RR = 2'b00;
    localparam logic [1:0] CL_ALU_IM = 2'b01;
    localparam logic [1:0] CL_JUMP   = 2'b10;

    localparam logic [3:0] JF_J   = 4'b0000;
    localparam logic [3:0] JF_JZ  = 4'b0001;
    localparam logic [3:0] JF_JNZ = 4'b0010;

    localparam logic [5:0] OP_NOP  = 6'b110000;
    localparam logic [5:0] OP_HALT = 6'b111111;

    logic [1:0]        state;
    logic [1:0]        next_state;
    logic [BOOT_W-1:0] boot_cnt;
    logic              retire_c;
    logic              illegal_op_c;
    logic              taken_c;

    // State and boot counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_BOOT;
            boot_cnt <= '0;
        end else begin
            state <= next_state;
            if (state == ST_BOOT) begin
                boot_cnt <= boot_cnt + BOOT_W'(1);
            end else begin
                boot_cnt <= '0;
            end
        end
    end

    // Next-state logic and combinational control decode
    always_comb begin
        next_state   = state;
        s_inc        = 1'b1;
        s_inm        = 1'b0;
        we           = 1'b0;
        wez          = 1'b0;
        ALUOp        = 3'b000;
        pc_en        = 1'b0;
        halted       = 1'b0;
        retire_c     = 1'b0;
        illegal_op_c = 1'b0;
        taken_c      = 1'b0;

        case (state)
            ST_BOOT: begin
                if (boot_cnt == BOOT_LAST) begin
                    next_state = ST_RUN;
                end
            end

            ST_RUN: begin
                pc_en    = 1'b1;
                retire_c = 1'b1;
                case (Opcode[5:4])
                    CL_ALU_RR: begin
                        ALUOp = Opcode[2:0];
                        we    = 1'b1;
                        wez   = 1'b1;
                    end
                    CL_ALU_IM: begin
                        ALUOp = Opcode[2:0];
                        s_inm = 1'b1;
                        we    = 1'b1;
                        wez   = 1'b1;
                    end
                    CL_JUMP: begin
                        case (Opcode[3:0])
                            JF_J:    taken_c = 1'b1;
                            JF_JZ:   taken_c = zero;
                            JF_JNZ:  taken_c = !zero;
                            default: illegal_op_c = 1'b1;
                        endcase
                        if (taken_c) begin
                            s_inc      = 1'b0;
                            next_state = ST_FLUSH;
                        end
                    end
                    default: begin
                        if (Opcode == OP_HALT) begin
                            pc_en      = 1'b0;
                            retire_c   = 1'b0;
                            next_state = ST_HALT;
                        end else if (Opcode != OP_NOP) begin
                            illegal_op_c = 1'b1;
                        end
                    end
                endcase
`ifdef UC_ILLEGAL_TRAP_EN
                // Trapped opcode keeps idle controls and is not counted
                if (illegal_op_c) begin
                    retire_c   = 1'b0;
                    next_state = ST_HALT;
                end
`endif
            end

            ST_FLUSH: begin
                pc_en      = 1'b1;
                next_state = ST_RUN;
            end

            default: begin
                halted = 1'b1;
            end
        endcase
    end

    // Saturating retired-instruction counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired <= '0;
        end else if (retire_c && (retired != RET_MAX)) begin
            retired <= retired + RET_W'(1);
        end
    end

`ifdef UC_ILLEGAL_TRAP_EN
    logic illegal_q;

    // Sticky illegal-opcode flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            illegal_q <= 1'b0;
        end else if (illegal_op_c) begin
            illegal_q <= 1'b1;
        end
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_uc_fsm.sv
// Scoreboard bench for uc_fsm: directed opcode vectors with hand-computed controls.
module tb_uc_fsm;

    localparam int unsigned RET_W = 4;

    typedef struct packed {
        logic [7:0]       tag;
        logic             s_inc;
        logic             s_inm;
        logic             we;
        logic             wez;
        logic [2:0]       alu;
        logic             pc_en;
        logic             halted;
        logic             illegal;
        logic [RET_W-1:0] ret;
    } exp_t;

    logic             clk;
    logic             reset;
    logic [5:0]       Opcode;
    logic             zero;
    logic             s_inc;
    logic             s_inm;
    logic             we;
    logic             wez;
    logic [2:0]       ALUOp;
    logic             pc_en;
    logic             halted;
    logic             illegal;
    logic [RET_W-1:0] retired;

    exp_t sb[$];
    int   n_cmp;
    int   n_bad;

    uc_fsm #(.RET_W(RET_W), .BOOT_CYCLES(1)) dut (
        .clk     (clk),
        .reset   (reset),
        .Opcode  (Opcode),
        .zero    (zero),
        .s_inc   (s_inc),
        .s_inm   (s_inm),
        .we      (we),
        .wez     (wez),
        .ALUOp   (ALUOp),
        .pc_en   (pc_en),
        .halted  (halted),
        .illegal (illegal),
        .retired (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [7:0] tag, input logic si, input logic sm,
                                input logic w, input logic wz, input logic [2:0] a,
                                input logic pe, input logic h, input logic il,
                                input logic [RET_W-1:0] r);
        exp_t e;
        e.tag = tag; e.s_inc = si; e.s_inm = sm; e.we = w; e.wez = wz;
        e.alu = a; e.pc_en = pe; e.halted = h; e.illegal = il; e.ret = r;
        return e;
    endfunction

    // Drive one cycle of inputs and queue what the DUT must show in that cycle
    task automatic step(input logic [5:0] op, input logic z, input exp_t e);
        Opcode = op;
        zero   = z;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [7:0] tag, input logic [5:0] op, input logic pe,
                        input logic h, input logic il, input logic [RET_W-1:0] r);
        step(op, 1'b0, mk(tag, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, pe, h, il, r));
    endtask

    // Monitor: compare the oldest expectation against the live outputs mid-cycle
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            exp_t a;
            e = sb.pop_front();
            a = mk(e.tag, s_inc, s_inm, we, wez, ALUOp, pc_en, halted, illegal, retired);
            n_cmp++;
            if (a != e) begin
                n_bad++;
                $display("FAIL step%0d: got s_inc=%0b s_inm=%0b we=%0b wez=%0b alu=%0d pc_en=%0b halted=%0b illegal=%0b retired=%0d, want s_inc=%0b s_inm=%0b we=%0b wez=%0b alu=%0d pc_en=%0b halted=%0b illegal=%0b retired=%0d",
                         e.tag, a.s_inc, a.s_inm, a.we, a.wez, a.alu, a.pc_en, a.halted, a.illegal, a.ret,
                         e.s_inc, e.s_inm, e.we, e.wez, e.alu, e.pc_en, e.halted, e.illegal, e.ret);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        reset  = 1'b0;
        Opcode = 6'd0;
        zero   = 1'b0;
        @(posedge clk);
        #1;

        // Reset held: everything at reset values
        for (int i = 0; i < 3; i++) idle(8'(i), 6'b000101, 1'b0, 1'b0, 1'b0, 4'd0);
        reset = 1'b1;
        idle(8'd3, 6'b000101, 1'b0, 1'b0, 1'b0, 4'd0);

        // RUN: ALU reg-reg, ALU immediate, NOP
        step(6'b000101, 1'b0, mk(8'd4, 1, 0, 1, 1, 3'd5, 1, 0, 0, 4'd0));
        step(6'b010011, 1'b0, mk(8'd5, 1, 1, 1, 1, 3'd3, 1, 0, 0, 4'd1));
        idle(8'd6, 6'b110000, 1'b1, 1'b0, 1'b0, 4'd2);

        // JZ taken, then FLUSH discards an ALU op
        step(6'b100001, 1'b1, mk(8'd7, 0, 0, 0, 0, 3'd0, 1, 0, 0, 4'd3));
        idle(8'd8, 6'b000101, 1'b1, 1'b0, 1'b0, 4'd4);

        // JNZ with zero=1 and JZ with zero=0: not taken, no bubble
        step(6'b100010, 1'b1, mk(8'd9, 1, 0, 0, 0, 3'd0, 1, 0, 0, 4'd4));
        step(6'b100001, 1'b0, mk(8'd10, 1, 0, 0, 0, 3'd0, 1, 0, 0, 4'd5));

        // JNZ taken, then a second jump lands in FLUSH and is dropped
        step(6'b100010, 1'b0, mk(8'd11, 0, 0, 0, 0, 3'd0, 1, 0, 0, 4'd6));
        step(6'b100000, 1'b0, mk(8'd12, 1, 0, 0, 0, 3'd0, 1, 0, 0, 4'd7));
        step(6'b100000, 1'b0, mk(8'd13, 0, 0, 0, 0, 3'd0, 1, 0, 0, 4'd7));
        idle(8'd14, 6'b110000, 1'b1, 1'b0, 1'b0, 4'd8);

        // Illegal opcode
        idle(8'd15, 6'b110101, 1'b1, 1'b0, 1'b0, 4'd8);
`ifdef UC_ILLEGAL_TRAP_EN
        idle(8'd16, 6'b100110, 1'b0, 1'b1, 1'b1, 4'd8);
        idle(8'd17, 6'b111111, 1'b0, 1'b1, 1'b1, 4'd8);
        for (int i = 0; i < 10; i++) idle(8'(18 + i), 6'b000001, 1'b0, 1'b1, 1'b1, 4'd8);
`else
        idle(8'd16, 6'b100110, 1'b1, 1'b0, 1'b0, 4'd9);
        // HALT instruction itself, then ALU ops ignored
        idle(8'd17, 6'b111111, 1'b0, 1'b0, 1'b0, 4'd10);
        for (int i = 0; i < 10; i++) idle(8'(18 + i), 6'b000001, 1'b0, 1'b1, 1'b0, 4'd10);
`endif

        // Reset mid-HALT clears immediately
        reset = 1'b0;
        idle(8'd28, 6'b000001, 1'b0, 1'b0, 1'b0, 4'd0);
        reset = 1'b1;
        idle(8'd29, 6'b000001, 1'b0, 1'b0, 1'b0, 4'd0);

        // retired saturates at 15
        for (int i = 0; i < 20; i++)
            idle(8'(30 + i), 6'b110000, 1'b1, 1'b0, 1'b0, (i > 15) ? 4'd15 : 4'(i));

        // Reset mid-FLUSH
        step(6'b100000, 1'b0, mk(8'd50, 0, 0, 0, 0, 3'd0, 1, 0, 0, 4'd15));
        reset = 1'b0;
        idle(8'd51, 6'b000101, 1'b0, 1'b0, 1'b0, 4'd0);
        reset = 1'b1;

        repeat (3) if (sb.size() > 0) @(negedge clk);
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
